// File: rtl/toggle_event_receiver.sv
// Receiving end of a toggle-encoded event link: synchronises t_in, turns each level
// change into a one-cycle pulse, holds it for a valid/ready consumer and acks with a toggle.
module toggle_event_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             t_in,
    input  logic             evt_ready,
    input  logic             clr_ovr,
    output logic             pulse,
    output logic             evt_valid,
    output logic             ack_t,
    output logic [CNT_W-1:0] count,
    output logic             overrun,
    output logic             dbg_state
);

    // Handshake: an event is transferred on a rising edge where evt_valid && evt_ready;
    // evt_valid never drops without that transfer, evt_ready is don't-care while idle.
    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic                   det;
    logic                   accept;

    // The line is taken as low at reset, so a high t_in after release counts as one toggle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], t_in};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign det    = sync[SYNC_STAGES-1] ^ prev;
    assign accept = (state == PEND) && evt_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (det) state_nxt = PEND;
            PEND:    if (accept && !det) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pulse   <= 1'b0;
            ack_t   <= 1'b0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            state <= state_nxt;
            pulse <= det;
            if (accept)
                ack_t <= ~ack_t;
            if (det)
                count <= count + 1'b1;
            // A new toggle merging into an unaccepted event wins over a clear request.
            if ((state == PEND) && !evt_ready && det)
                overrun <= 1'b1;
            else if (clr_ovr)
                overrun <= 1'b0;
        end
    end

    assign evt_valid = (state == PEND);
    assign dbg_state = state;

endmodule

// File: tb/tb_toggle_event_receiver.sv
// Directed bench for toggle_event_receiver: default instance plus a CNT_W=3 instance
// sharing the same stimulus for the wrap check.
module tb_toggle_event_receiver;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       t_in = 1'b0;
    logic       evt_ready = 1'b0;
    logic       clr_ovr = 1'b0;
    logic       pulse, evt_valid, ack_t, overrun, dbg_state;
    logic [7:0] count;
    logic       pulse3, evt_valid3, ack_t3, overrun3, dbg_state3;
    logic [2:0] count3;
    int         tests = 0;
    int         failed = 0;
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    toggle_event_receiver dut (
        .clk(clk), .reset(reset), .t_in(t_in), .evt_ready(evt_ready), .clr_ovr(clr_ovr),
        .pulse(pulse), .evt_valid(evt_valid), .ack_t(ack_t), .count(count),
        .overrun(overrun), .dbg_state(dbg_state)
    );

    toggle_event_receiver #(.SYNC_STAGES(2), .CNT_W(3)) dut3 (
        .clk(clk), .reset(reset), .t_in(t_in), .evt_ready(evt_ready), .clr_ovr(clr_ovr),
        .pulse(pulse3), .evt_valid(evt_valid3), .ack_t(ack_t3), .count(count3),
        .overrun(overrun3), .dbg_state(dbg_state3)
    );

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        t_in = 1'b0; evt_ready = 1'b0; clr_ovr = 1'b0;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1);
            tests++;
            if ({pulse, evt_valid, ack_t, overrun, dbg_state} !== 5'b0 || count !== 8'd0) begin
                failed++;
                $display("FAIL reset_c%0d got p%b v%b a%b o%b s%b cnt%0d exp all 0",
                         i, pulse, evt_valid, ack_t, overrun, dbg_state, count);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        step(1);
        t_in = 1'b1; evt_ready = 1'b1;
        step(2);
        tests++;
        if (pulse !== 1'b0 || evt_valid !== 1'b0) begin
            failed++; $display("FAIL single_e2 got p%b v%b exp p0 v0", pulse, evt_valid);
        end
        step(1);
        tests++;
        if (pulse !== 1'b1 || evt_valid !== 1'b1 || count !== 8'd1 || ack_t !== 1'b0) begin
            failed++;
            $display("FAIL single_e3 got p%b v%b cnt%0d a%b exp p1 v1 cnt1 a0", pulse, evt_valid, count, ack_t);
        end
        step(1);
        tests++;
        if (pulse !== 1'b0 || evt_valid !== 1'b0 || count !== 8'd1 || ack_t !== 1'b1) begin
            failed++;
            $display("FAIL single_e4 got p%b v%b cnt%0d a%b exp p0 v0 cnt1 a1", pulse, evt_valid, count, ack_t);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        t_in = 1'b1;
        step(3);
        tests++;
        if (evt_valid !== 1'b1 || count !== 8'd1 || overrun !== 1'b0) begin
            failed++; $display("FAIL ovr_first got v%b cnt%0d o%b exp v1 cnt1 o0", evt_valid, count, overrun);
        end
        step(2);
        t_in = 1'b0;
        step(3);
        tests++;
        if (evt_valid !== 1'b1 || count !== 8'd2 || overrun !== 1'b1 || pulse !== 1'b1) begin
            failed++;
            $display("FAIL ovr_second got v%b cnt%0d o%b p%b exp v1 cnt2 o1 p1", evt_valid, count, overrun, pulse);
        end
        step(2);
        tests++;
        if (evt_valid !== 1'b1 || ack_t !== 1'b0) begin
            failed++; $display("FAIL ovr_hold got v%b a%b exp v1 a0", evt_valid, ack_t);
        end
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        step(1);
        tests++;
        if (evt_valid !== 1'b0 || ack_t !== 1'b1 || overrun !== 1'b1) begin
            failed++; $display("FAIL ovr_accept got v%b a%b o%b exp v0 a1 o1", evt_valid, ack_t, overrun);
        end
    endtask

    task automatic test_priority();
        do_reset();
        t_in = 1'b1;
        step(5);
        t_in = 1'b0;
        step(5);
        tests++;
        if (overrun !== 1'b1) begin
            failed++; $display("FAIL prio_setup got o%b exp o1", overrun);
        end
        t_in = 1'b1;
        step(2);
        clr_ovr = 1'b1;
        step(1);
        tests++;
        if (overrun !== 1'b1 || count !== 8'd3) begin
            failed++; $display("FAIL prio_set_wins got o%b cnt%0d exp o1 cnt3", overrun, count);
        end
        step(1);
        clr_ovr = 1'b0;
        tests++;
        if (overrun !== 1'b0) begin
            failed++; $display("FAIL prio_clear got o%b exp o0", overrun);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        t_in = 1'b1;
        step(5);
        t_in = 1'b0;
        step(2);
        evt_ready = 1'b1;
        step(1);
        tests++;
        if (evt_valid !== 1'b1 || ack_t !== 1'b1 || count !== 8'd2 || overrun !== 1'b0 || pulse !== 1'b1) begin
            failed++;
            $display("FAIL b2b_same_edge got v%b a%b cnt%0d o%b p%b exp v1 a1 cnt2 o0 p1",
                     evt_valid, ack_t, count, overrun, pulse);
        end
        step(1);
        evt_ready = 1'b0;
        tests++;
        if (evt_valid !== 1'b0 || ack_t !== 1'b0) begin
            failed++; $display("FAIL b2b_drain got v%b a%b exp v0 a0", evt_valid, ack_t);
        end
    endtask

    task automatic test_wrap_reset();
        logic [2:0] exp;
        do_reset();
        evt_ready = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            exp_q.push_back(3'(i % 8));
            t_in = ~t_in;
            step(3);
            exp = exp_q.pop_front();
            tests++;
            if (count3 !== exp) begin
                failed++; $display("FAIL wrap_t%0d got cnt%0d exp cnt%0d", i, count3, exp);
            end
            step(2);
        end
        tests++;
        if (count3 !== 3'd1 || count !== 8'd9 || ack_t3 !== 1'b1) begin
            failed++; $display("FAIL wrap_final got cnt3=%0d cnt=%0d a%b exp 1 9 a1", count3, count, ack_t3);
        end
        evt_ready = 1'b0;
        t_in = ~t_in;
        step(3);
        tests++;
        if (evt_valid3 !== 1'b1 || count3 !== 3'd2) begin
            failed++; $display("FAIL wrap_pend got v%b cnt%0d exp v1 cnt2", evt_valid3, count3);
        end
        reset = 1'b1;
        #1;
        tests++;
        if (evt_valid3 !== 1'b0 || ack_t3 !== 1'b0 || count3 !== 3'd0 ||
            evt_valid !== 1'b0 || ack_t !== 1'b0 || count !== 8'd0) begin
            failed++;
            $display("FAIL async_reset got v%b a%b cnt3=%0d v%b a%b cnt=%0d exp all 0",
                     evt_valid3, ack_t3, count3, evt_valid, ack_t, count);
        end
        t_in = 1'b0;
        step(1);
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_overrun();
        test_priority();
        test_back_to_back();
        test_wrap_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #50000;
        failed++;
        $display("FAIL watchdog expired");
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
